// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the RV32 multi-cycle control path.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt,
    StErr
  } seq_state_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_LD   = 2'b01;
  localparam logic [1:0] MEM_ST   = 2'b10;

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter shared by the instruction and data request states.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] Last = CntW'(MEM_TIMEOUT - 1);

  logic [CntW-1:0] cnt_q;

  assign expired = (cnt_q == Last);

  // Saturates at Last so the counter never wraps while the FSM leaves the state.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (tick && !expired) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle instruction sequencer: owns every state-changing strobe of the datapath.
module multicycle_seq
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             dec_regWEn,
  input  logic [1:0]       dec_memRW,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic [1:0]       dmem_rw,
  output logic             reg_we,
  output logic             pc_en,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             in_req, ack, timer_clr, timer_tick, expired;

  assign in_req     = (state_q == StFetch) || (state_q == StMem);
  assign ack        = ((state_q == StFetch) && imem_ack) || ((state_q == StMem) && dmem_ack);
  assign timer_clr  = !in_req;
  assign timer_tick = in_req && !ack;
  assign retired    = retired_q;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .tick   (timer_tick),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StWb) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  // An ack in the cycle the timer expires takes priority over the error.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (run) state_d = StFetch;
      StFetch: begin
        if (imem_ack)     state_d = StDecode;
        else if (expired) state_d = StErr;
      end
      StDecode: begin
        if (!op_supported(opcode) || (dec_memRW == 2'b11)) state_d = StHalt;
        else                                               state_d = StExec;
      end
      StExec:   state_d = (dec_memRW != MEM_NONE) ? StMem : StWb;
      StMem: begin
        if (dmem_ack)     state_d = StWb;
        else if (expired) state_d = StErr;
      end
      StWb:     state_d = run ? StFetch : StIdle;
      StHalt:   state_d = StHalt;
      StErr:    state_d = StErr;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_rw  = MEM_NONE;
    reg_we   = 1'b0;
    pc_en    = 1'b0;
    busy     = 1'b0;
    halted   = 1'b0;
    err      = 1'b0;
    unique case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
        busy     = 1'b1;
      end
      StDecode, StExec: busy = 1'b1;
      StMem: begin
        dmem_req = 1'b1;
        dmem_rw  = dec_memRW;
        busy     = 1'b1;
      end
      StWb: begin
        pc_en  = 1'b1;
        reg_we = dec_regWEn && (opcode != OP_STORE);
        busy   = 1'b1;
      end
      StHalt:  halted = 1'b1;
      StErr:   err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/multicycle_seq.md
# multicycle_seq

Multi-cycle sequencer for the RV32 core datapath. It splits each instruction into FETCH/DECODE/EXECUTE/MEM/WB steps and gates the datapath's state-changing strobes: PC update, instruction latch, register-file write and data-memory request. It handles wait-stated instruction and data memories through req/ack handshakes. It sits between `control_block` (combinational decode) and the datapath, and owns all write enables.

## Interface
- `MEM_TIMEOUT`, default 16: maximum cycles a memory request may wait for ack before the block enters ERR.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: single clock, all state changes on rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `run` in 1: allows a new instruction to start.
- `opcode` in 7: opcode of the latched instruction.
- `dec_regWEn` in 1: register-write request from `control_block`.
- `dec_memRW` in 2: memory op from `control_block` (00 none, 01 load, 10 store, 11 invalid).
- `imem_ack` in 1: instruction word valid this cycle.
- `dmem_ack` in 1: data access complete this cycle.
- `imem_req` out 1: instruction fetch request.
- `ir_we` out 1: latch the instruction register.
- `dmem_req` out 1: data memory request.
- `dmem_rw` out 2: data op forwarded with `dmem_req`; 00 otherwise.
- `reg_we` out 1: register-file write strobe.
- `pc_en` out 1: advance the PC.
- `busy` out 1: high in any state except IDLE, HALT and ERR.
- `halted` out 1: high in HALT.
- `err` out 1: high in ERR.
- `retired` out CNT_W: count of completed instructions.

## Operation
- States:
  - IDLE: reset state.
  - FETCH.
  - DECODE.
  - EXEC.
  - MEM.
  - WB.
  - HALT: illegal instruction.
  - ERR: memory timeout.
- IDLE: goes to FETCH when `run`=1, otherwise stays.
- FETCH:
  - `imem_req`=1.
  - When `imem_ack`=1: `ir_we`=1 the same cycle, then go to DECODE.
- DECODE: one cycle.
  - Supported opcodes: 0110011 (R), 0010011 (I-ALU), 0000011 (LOAD), 0100011 (STORE).
  - Any other opcode, or `dec_memRW`=11, goes to HALT.
  - Otherwise go to EXEC.
- EXEC: one cycle. Go to MEM if `dec_memRW`≠00, otherwise go to WB.
- MEM:
  - `dmem_req`=1 and `dmem_rw`=`dec_memRW`, held stable until `dmem_ack`.
  - On ack go to WB.
- WB: one cycle.
  - `pc_en`=1.
  - `reg_we`=`dec_regWEn`; forced to 0 for STORE.
  - `retired` increments.
  - Next state is FETCH if `run`=1, else IDLE.
- Timeout: a wait counter clears on entry to FETCH or MEM and increments each cycle without ack. When it reaches `MEM_TIMEOUT`-1 with no ack, go to ERR; the request drops on the next cycle.
- HALT and ERR are sticky until `rst`. No strobes are asserted in either state.
- All outputs are decoded from the state register (Moore), except `ir_we`, which is ANDed with `imem_ack`.

## Timing
- Reset values:
  - State is IDLE.
  - `retired`=0 and the wait counter is 0.
  - All strobes and requests are 0; `dmem_rw`=00; `busy`, `halted` and `err` are 0.
- Reset mid-operation: all requests deassert the cycle after `rst` is sampled, and any pending transaction is abandoned. An ack arriving during or after reset is ignored.
- Latency with zero wait states, from FETCH entry to the `pc_en` pulse:
  - R/I: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LOAD/STORE: 5 cycles.
  - Each memory wait cycle adds 1.
- `pc_en`, `reg_we` and `ir_we` are each exactly one cycle wide per instruction.
- `run` is sampled only in IDLE and WB. Dropping `run` mid-instruction completes the current instruction.
- `retired` wraps from all-ones to 0 with no flag.
- An ack in the same cycle the timeout fires wins: the transaction completes and the block does not enter ERR.
- `imem_ack` or `dmem_ack` outside its request state is ignored.

## Structure
- Package `riscv_ctrl_pkg`:
  - State enum.
  - Opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE).
  - `memRW` encodings (MEM_NONE, MEM_LD, MEM_ST).
- Sub-module `mem_wait_timer`, instantiated once:
  - Inputs `clr` and `tick`; output `expired`, parameterised by `MEM_TIMEOUT`.
  - Shared by FETCH and MEM because only one request is active at a time.

## Test plan
- Reset then `run`=1, R-type 0x010787B3, acks immediate → `imem_req` in cycle 1, `pc_en` and `reg_we` in cycle 4, `retired`=1.
- LOAD (opcode 0000011) with `dmem_ack` delayed 3 cycles → `dmem_rw`=01 held 4 cycles, `reg_we` in cycle 8, one `pc_en` pulse.
- STORE (opcode 0100011), `dec_regWEn`=1 → `dmem_rw`=10 and `reg_we` stays 0 in WB.
- Opcode 1111111 → HALT after DECODE; `halted`=1, no further `imem_req` or `pc_en` until `rst`.
- `dmem_ack` never arrives with `MEM_TIMEOUT`=16 → `err`=1 exactly 16 cycles after MEM entry; ack on cycle 16 instead → completes normally. `rst` asserted mid-MEM → IDLE and `dmem_req`=0 the next cycle.
- `retired` preloaded to 0xFFFFFFFF via force, one instruction retired → `retired`=0.
